// File: rtl/hazard_sb.sv
// Hazard and exception controller for the 5-stage MIPS core.
// A per-register scoreboard counts down the cycles until each pending result
// reaches a D-stage forwarding path, so dependent instructions stall only as
// long as their producer really needs. A small FSM holds off the exception
// redirect until outstanding bus transactions have drained.
module hazard_sb #(
  parameter int          RW        = 5,
  parameter int          LAT_W     = 2,
  parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE = 32'h0000000E
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    rsD,
  input  logic [RW-1:0]    rtD,
  input  logic             useRsD,
  input  logic             useRtD,
  input  logic             cmpD,
  input  logic [RW-1:0]    wregD,
  input  logic             regwriteD,
  input  logic [LAT_W-1:0] latD,
  input  logic [RW-1:0]    rsE,
  input  logic [RW-1:0]    rtE,
  input  logic [RW-1:0]    writeregM,
  input  logic [RW-1:0]    writeregW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             stall_divE,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      except_typeM,
  input  logic [31:0]      epc_i,
  output logic [1:0]       forwardaD,
  output logic [1:0]       forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             stallW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [31:0]      newpc,
  output logic             redirect
);

  localparam int NREG = 2 ** RW;

  typedef enum logic [1:0] {IDLE, WAIT, REDIR} stateT;

  stateT            state;
  stateT            stateNext;
  logic [LAT_W-1:0] cnt [NREG];
  logic             ext;
  logic             excTake;
  logic             busyRs;
  logic             busyRt;
  logic             sbStall;
  logic             issue;

  // M-stage result wins over W-stage; register 0 is never forwarded.
  function automatic logic [1:0] fwdSel(input logic [RW-1:0] src,
                                        input logic [RW-1:0] regM,
                                        input logic          weM,
                                        input logic [RW-1:0] regW,
                                        input logic          weW);
    if (src != '0 && weM && regM == src)      return 2'b10;
    else if (src != '0 && weW && regW == src) return 2'b01;
    else                                      return 2'b00;
  endfunction

  assign ext     = stallreq_from_if | stallreq_from_mem;
  assign excTake = (state == IDLE) && (except_typeM != '0);
  assign issue   = ~stallD & ~flushE & regwriteD & (wregD != '0);

  assign forwardaD = fwdSel(rsD, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardbD = fwdSel(rtD, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardaE = fwdSel(rsE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardbE = fwdSel(rtE, writeregM, regwriteM, writeregW, regwriteW);

  // Scoreboard lookup: compares in D need the value now (count 0); E consumers
  // can take it off the forwarding path one cycle later (count <= 1).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    busyRs = 1'b0;
    busyRt = 1'b0;
    if (useRsD) busyRs = cmpD ? (cnt[rsD] != '0) : (cnt[rsD] > LAT_W'(1));
    if (useRtD) busyRt = cmpD ? (cnt[rtD] != '0) : (cnt[rtD] > LAT_W'(1));
  end

  assign sbStall = (state == IDLE) && (busyRs || busyRt);

  // Exception FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Exception FSM next-state: wait for the bus to drain before redirecting.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (except_typeM != '0) stateNext = ext ? WAIT : REDIR;
      WAIT:    if (!ext)               stateNext = REDIR;
      REDIR:                           stateNext = IDLE;
      default:                         stateNext = IDLE;
    endcase
  end

  // Stall/flush/redirect outputs; an exception overrides every stall source.
  always_comb begin
    stallF   = 1'b0;
    stallD   = 1'b0;
    stallE   = 1'b0;
    stallM   = 1'b0;
    stallW   = 1'b0;
    flushF   = 1'b0;
    flushD   = 1'b0;
    flushE   = 1'b0;
    flushM   = 1'b0;
    flushW   = 1'b0;
    redirect = 1'b0;
    case (state)
      IDLE: begin
        if (excTake) begin
          flushF = 1'b1;
          flushD = 1'b1;
          flushE = 1'b1;
          flushM = 1'b1;
          flushW = 1'b1;
        end else begin
          stallF = sbStall | stall_divE | ext;
          stallD = sbStall | stall_divE | ext;
          stallE = stall_divE | stallreq_from_mem;
          stallM = stall_divE | stallreq_from_mem;
          stallW = stall_divE | stallreq_from_mem;
          flushE = sbStall & ~(stall_divE | stallreq_from_mem);
        end
      end
      WAIT: begin
        stallF = 1'b1;
        flushD = 1'b1;
        flushE = 1'b1;
        flushM = 1'b1;
        flushW = 1'b1;
      end
      REDIR: begin
        redirect = 1'b1;
        flushD   = 1'b1;
        flushE   = 1'b1;
        flushM   = 1'b1;
        flushW   = 1'b1;
      end
      default: ;
    endcase
  end

  // Redirect target, captured when the exception is taken at M.
  always_ff @(posedge clk) begin
    if (rst)          newpc <= '0;
    else if (excTake) newpc <= (except_typeM == ERET_CODE) ? epc_i : EXC_VEC;
  end

  // Scoreboard counters: exception clear beats issue, issue beats countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the scoreboard is a flop array, not RAM, so it is reset like any other state.
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (excTake)                         cnt[r] <= '0;
        else if (issue && wregD == RW'(r))   cnt[r] <= latD;
        else if (!stallE && cnt[r] != '0)    cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb. Each cycle the stimulus pushes the
// outputs it expects; a negedge monitor pops and compares them.
module tb_hazard_sb;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;

  // {stallF,stallD,stallE,stallM,stallW, flushF,flushD,flushE,flushM,flushW, redirect}
  localparam logic [10:0] NONE = 11'b00000_00000_0;
  localparam logic [10:0] SBST = 11'b11000_00100_0;
  localparam logic [10:0] HOLD = 11'b11111_00000_0;
  localparam logic [10:0] IFST = 11'b11000_00000_0;
  localparam logic [10:0] EXC  = 11'b00000_11111_0;
  localparam logic [10:0] WT   = 11'b10000_01111_0;
  localparam logic [10:0] RD   = 11'b00000_01111_1;

  typedef struct {
    string       tag;
    logic [10:0] ctl;
    logic [7:0]  fwd;   // {forwardaD, forwardbD, forwardaE, forwardbE}
    bit          chkPc;
    logic [31:0] pc;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rsD, rtD, wregD, rsE, rtE, writeregM, writeregW;
  logic        useRsD, useRtD, cmpD, regwriteD, regwriteM, regwriteW;
  logic [1:0]  latD;
  logic        stall_divE, stallreq_from_if, stallreq_from_mem;
  logic [31:0] except_typeM, epc_i;
  logic [1:0]  forwardaD, forwardbD, forwardaE, forwardbE;
  logic        stallF, stallD, stallE, stallM, stallW;
  logic        flushF, flushD, flushE, flushM, flushW;
  logic [31:0] newpc;
  logic        redirect;

  expT q[$];
  int  total = 0;
  int  bad   = 0;

  hazard_sb dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD), .cmpD(cmpD),
    .wregD(wregD), .regwriteD(regwriteD), .latD(latD),
    .rsE(rsE), .rtE(rtE),
    .writeregM(writeregM), .writeregW(writeregW),
    .regwriteM(regwriteM), .regwriteW(regwriteW),
    .stall_divE(stall_divE), .stallreq_from_if(stallreq_from_if),
    .stallreq_from_mem(stallreq_from_mem),
    .except_typeM(except_typeM), .epc_i(epc_i),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .newpc(newpc), .redirect(redirect)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsD = '0; rtD = '0; useRsD = 1'b0; useRtD = 1'b0; cmpD = 1'b0;
    wregD = '0; regwriteD = 1'b0; latD = '0;
    rsE = '0; rtE = '0; writeregM = '0; writeregW = '0;
    regwriteM = 1'b0; regwriteW = 1'b0;
    stall_divE = 1'b0; stallreq_from_if = 1'b0; stallreq_from_mem = 1'b0;
    except_typeM = '0; epc_i = '0;
  endtask

  task automatic push(input string tag, input logic [10:0] ctl,
                      input logic [7:0] fwd = 8'h00,
                      input bit chkPc = 1'b0, input logic [31:0] pc = 32'h0);
    expT e;
    e.tag = tag; e.ctl = ctl; e.fwd = fwd; e.chkPc = chkPc; e.pc = pc;
    q.push_back(e);
  endtask

  // Compare mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      expT e;
      e = q.pop_front();
      check({e.tag, "_ctl"},
            32'({stallF, stallD, stallE, stallM, stallW,
                 flushF, flushD, flushE, flushM, flushW, redirect}), 32'(e.ctl));
      check({e.tag, "_fwd"}, 32'({forwardaD, forwardbD, forwardaE, forwardbE}), 32'(e.fwd));
      if (e.chkPc) check({e.tag, "_pc"}, newpc, e.pc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    push("reset", NONE, 8'h00, 1'b1, 32'h0);

    // ALU producer: one-cycle latency, consumer in D does not stall.
    tick(); regwriteD = 1'b1; wregD = 5'd8; latD = 2'd1;         push("alu_iss", NONE);
    tick(); useRsD = 1'b1; rsD = 5'd8;                            push("alu_use", NONE);
    tick(); rsE = 5'd8; regwriteM = 1'b1; writeregM = 5'd8;
            regwriteW = 1'b1; writeregW = 5'd8;                   push("alu_fwdE", NONE, 8'b00_00_10_00);

    // Load producer: one bubble, then forward from W.
    tick(); regwriteD = 1'b1; wregD = 5'd9; latD = 2'd2;         push("lw_iss", NONE);
    tick(); useRsD = 1'b1; rsD = 5'd9;                            push("lw_stall", SBST);
    tick(); useRsD = 1'b1; rsD = 5'd9;                            push("lw_go", NONE);
    tick(); rsE = 5'd9; regwriteW = 1'b1; writeregW = 5'd9;      push("lw_fwdE", NONE, 8'b00_00_01_00);

    // Load feeding a branch compare: two stall cycles, then W forward into D.
    tick(); regwriteD = 1'b1; wregD = 5'd10; latD = 2'd2;        push("lwb_iss", NONE);
    tick(); useRsD = 1'b1; cmpD = 1'b1; rsD = 5'd10;              push("lwb_stall1", SBST);
    tick(); useRsD = 1'b1; cmpD = 1'b1; rsD = 5'd10;              push("lwb_stall2", SBST);
    tick(); useRsD = 1'b1; cmpD = 1'b1; rsD = 5'd10;
            regwriteW = 1'b1; writeregW = 5'd10;                  push("lwb_go", NONE, 8'b01_00_00_00);

    // ALU feeding a branch compare: one stall cycle, then M forward into D.
    tick(); regwriteD = 1'b1; wregD = 5'd12; latD = 2'd1;        push("alub_iss", NONE);
    tick(); useRsD = 1'b1; cmpD = 1'b1; rsD = 5'd12;              push("alub_stall", SBST);
    tick(); useRsD = 1'b1; cmpD = 1'b1; rsD = 5'd12;
            regwriteM = 1'b1; writeregM = 5'd12;                  push("alub_go", NONE, 8'b10_00_00_00);

    // Divider busy freezes the countdown; consumer releases one cycle after.
    tick(); regwriteD = 1'b1; wregD = 5'd11; latD = 2'd2;        push("div_iss", NONE);
    for (int i = 0; i < 4; i++) begin
      tick(); stall_divE = 1'b1; useRsD = 1'b1; rsD = 5'd11;     push("div_hold", HOLD);
    end
    tick(); useRsD = 1'b1; rsD = 5'd11;                           push("div_fall", SBST);
    tick(); useRsD = 1'b1; rsD = 5'd11;                           push("div_go", NONE);

    // Exception with the bus busy: flush, three WAIT cycles, then redirect.
    tick(); regwriteD = 1'b1; wregD = 5'd13; latD = 2'd3;        push("pre_exc", NONE);
    tick(); except_typeM = 32'd1; stallreq_from_mem = 1'b1;       push("exc_flush", EXC);
    tick(); except_typeM = 32'd1; stallreq_from_mem = 1'b1;       push("wait1", WT, 8'h00, 1'b1, EXC_VEC);
    tick(); except_typeM = 32'd1; stallreq_from_mem = 1'b1;       push("wait2", WT);
    tick(); except_typeM = 32'd1;                                 push("wait3", WT);
    tick();                                                       push("redir", RD, 8'h00, 1'b1, EXC_VEC);
    tick(); useRsD = 1'b1; cmpD = 1'b1; rsD = 5'd13;              push("sb_clear1", NONE);

    // ERET without bus stall: redirect next cycle to EPC; scoreboard cleared.
    tick(); regwriteD = 1'b1; wregD = 5'd13; latD = 2'd3;        push("pre_eret", NONE);
    tick(); except_typeM = 32'h0000000E; epc_i = 32'h80001234;    push("eret_flush", EXC);
    tick();                                                       push("eret_redir", RD, 8'h00, 1'b1, 32'h80001234);
    tick(); useRsD = 1'b1; cmpD = 1'b1; rsD = 5'd13;              push("sb_clear2", NONE);

    // Register 0 is never busy and never forwarded.
    tick(); regwriteD = 1'b1; wregD = 5'd0; latD = 2'd3;         push("r0_iss", NONE);
    tick(); useRsD = 1'b1; useRtD = 1'b1; cmpD = 1'b1;
            regwriteM = 1'b1; regwriteW = 1'b1;                   push("r0_use", NONE);

    // rt path of the scoreboard, plus W forward on the E rt operand.
    tick(); regwriteD = 1'b1; wregD = 5'd14; latD = 2'd2;        push("rt_iss", NONE);
    tick(); useRtD = 1'b1; rtD = 5'd14; rtE = 5'd5;
            regwriteW = 1'b1; writeregW = 5'd5;                   push("rt_stall", SBST, 8'b00_00_00_01);
    tick(); useRtD = 1'b1; rtD = 5'd14;                           push("rt_go", NONE);

    // Fetch-side bus stall holds only F and D.
    tick(); stallreq_from_if = 1'b1;                              push("if_stall", IFST);

    // Reset in WAIT returns to IDLE with redirect low and newpc cleared.
    tick(); except_typeM = 32'd1; stallreq_from_mem = 1'b1;       push("exc2_flush", EXC);
    tick(); stallreq_from_mem = 1'b1; rst = 1'b1;                 push("wait_rst", WT, 8'h00, 1'b1, EXC_VEC);
    tick();                                                       push("after_rst", NONE, 8'h00, 1'b1, 32'h0);

    tick();
    @(negedge clk);
    #1;
    check("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
